// File: rtl/comb_sweep_checker_if.sv
// comb_sweep_checker_if
//   Bundles the sweep control/result signals between the sweep engine and
//   whatever drives it (bench or bring-up harness).
//   Parameters: N = vector width, M = number of implementations compared.
//   Signals:
//     start            single-cycle sweep request
//     vec              vector driven to all implementations
//     y_in             M implementation outputs for vec
//     busy/done/pass   sweep status
//     mismatch_cnt     vectors with disagreeing outputs (N+1 bits)
//     first_fail_vec   first disagreeing vector, qualified by first_fail_valid
//   Modports: slave = sweep engine, master = driver/observer.
interface comb_sweep_checker_if #(
    parameter int N = 4,
    parameter int M = 4
) ();
    logic         start;
    logic [N-1:0] vec;
    logic [M-1:0] y_in;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   mismatch_cnt;
    logic [N-1:0] first_fail_vec;
    logic         first_fail_valid;

    modport slave (
        input  start, y_in,
        output vec, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_valid
    );

    modport master (
        output start, y_in,
        input  vec, busy, done, pass, mismatch_cnt, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/comb_sweep_checker.sv
// comb_sweep_checker
//   Exhaustive sweep engine: drives every N-bit vector in ascending order,
//   holds each for SETTLE cycles, then samples the M implementation outputs
//   and counts vectors where they do not all agree. Records the first
//   disagreeing vector. All outputs are registered.
//   Parameters: N (vector width), M (implementations, >= 2), SETTLE (>= 1).
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  comb_sweep_checker_if.slave (start, y_in in; vec and results out)
//   Configuration macro: COMB_SWEEP_STOP_ON_FAIL_EN -- when defined the sweep
//   halts at the first mismatch with vec frozen on the failing vector.
module comb_sweep_checker #(
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int SETTLE = 1
) (
    input logic                clk,
    input logic                rst,
    comb_sweep_checker_if.slave bus
);
    localparam int            CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST    = CW'(SETTLE - 1);
    localparam logic [N-1:0]  VEC_MAX = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
    localparam logic [1:0] HALT = 2'd3;
`endif

    logic [1:0]    state;
    logic [CW-1:0] settle_cnt;
    logic [N-1:0]  vec_q;
    logic [N:0]    mis_cnt_q;
    logic [N-1:0]  ffvec_q;
    logic          ffv_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;

    // Outputs disagree unless every implementation reports the same bit.
    logic       mis;
    logic [N:0] mis_cnt_next;
    assign mis          = ~((&bus.y_in) | ~(|bus.y_in));
    assign mis_cnt_next = mis_cnt_q + (N+1)'(mis);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_q      <= '0;
            mis_cnt_q  <= '0;
            ffvec_q    <= '0;
            ffv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (settle_cnt != LAST) begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end else begin
                        mis_cnt_q <= mis_cnt_next;
                        if (mis && !ffv_q) begin
                            ffvec_q <= vec_q;
                            ffv_q   <= 1'b1;
                        end
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
                        // First failure ends the sweep; vec stays on the culprit.
                        if (mis) begin
                            state  <= HALT;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= 1'b0;
                        end else
`endif
                        if (vec_q != VEC_MAX) begin
                            vec_q      <= vec_q + N'(1);
                            settle_cnt <= '0;
                        end else begin
                            // Last vector: vec holds all-ones, pass includes this sample.
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (mis_cnt_next == '0);
                        end
                    end
                end
                default: begin
                    // IDLE, DONE (and HALT) all accept a new start.
                    if (bus.start) begin
                        state      <= RUN;
                        settle_cnt <= '0;
                        vec_q      <= '0;
                        mis_cnt_q  <= '0;
                        ffv_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.vec              = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.mismatch_cnt     = mis_cnt_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.first_fail_valid = ffv_q;
endmodule

// File: tb/tb_comb_sweep_checker.sv
// tb_comb_sweep_checker
//   Runs two engines side by side (SETTLE=1 and SETTLE=3) against a shared
//   function with a per-vector error pattern, and compares results and sweep
//   length with a reference computed directly from the error table.
module tb_comb_sweep_checker;
    localparam int N = 4;
    localparam int M = 4;

    logic clk;
    logic rst;
    logic start;

    logic [M-1:0] err_tab [16];

    comb_sweep_checker_if #(.N(N), .M(M)) b1 ();
    comb_sweep_checker_if #(.N(N), .M(M)) b3 ();

    comb_sweep_checker #(.N(N), .M(M), .SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    comb_sweep_checker #(.N(N), .M(M), .SETTLE(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fn(input logic [N-1:0] v);
        return (v[0] & v[1]) | v[3];
    endfunction

    assign b1.start = start;
    assign b3.start = start;
    always_comb b1.y_in = {M{fn(b1.vec)}} ^ err_tab[b1.vec];
    always_comb b3.y_in = {M{fn(b3.vec)}} ^ err_tab[b3.vec];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference results
    int   e_cnt, e_first, e_vec;
    logic e_pass;

    task automatic model();
        int cnt;
        int first;
        logic [M-1:0] y;
        logic dis;
        cnt = 0;
        first = -1;
        for (int v = 0; v < 16; v++) begin
            y = {M{fn(4'(v))}} ^ err_tab[v];
            dis = 1'b0;
            for (int i = 1; i < M; i++) if (y[i] != y[0]) dis = 1'b1;
            if (dis) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        e_first = first;
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
        e_cnt = (first >= 0) ? 1 : 0;
        e_vec = (first >= 0) ? first : 15;
`else
        e_cnt = cnt;
        e_vec = 15;
`endif
        e_pass = (cnt == 0);
    endtask

    task automatic check_dut(input string nm, input logic busy, input logic done, input logic pass,
                             input logic [N:0] cnt, input logic [N-1:0] vec,
                             input logic [N-1:0] ffvec, input logic ffv,
                             input int cyc, input int settle);
        int exp_cyc;
        exp_cyc = (e_vec + 1) * settle;
        chk({nm, " cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " pass"}, 32'(pass), 32'(e_pass));
        chk({nm, " mismatch_cnt"}, 32'(cnt), 32'(e_cnt));
        chk({nm, " vec"}, 32'(vec), 32'(e_vec));
        chk({nm, " ffv"}, 32'(ffv), 32'(e_first >= 0));
        if (e_first >= 0) chk({nm, " first_fail_vec"}, 32'(ffvec), 32'(e_first));
    endtask

    function automatic logic [31:0] packed_out1();
        return {18'd0, b1.busy, b1.done, b1.pass, b1.first_fail_valid,
                b1.mismatch_cnt, b1.vec, b1.first_fail_vec};
    endfunction

    function automatic logic [31:0] packed_out3();
        return {18'd0, b3.busy, b3.done, b3.pass, b3.first_fail_valid,
                b3.mismatch_cnt, b3.vec, b3.first_fail_vec};
    endfunction

    // One sweep on both engines. pulse_v >= 0 pulses start when u1 is at that
    // vector; rst_v >= 0 resets when u1 reaches that vector and ends the run.
    task automatic run(input string nm, input int pulse_v, input int rst_v);
        int c, cyc1, cyc3;
        logic d1, d3, pulsed;
        model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, " busy after start"}, 32'(b1.busy & b3.busy), 32'd1);
        chk({nm, " vec after start"}, 32'({b1.vec, b3.vec}), 32'd0);
        c = 0; cyc1 = 0; cyc3 = 0; d1 = 1'b0; d3 = 1'b0; pulsed = 1'b0;
        while (c < 200 && !(d1 && d3)) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            c++;
            if (!d1 && b1.done) begin d1 = 1'b1; cyc1 = c; end
            if (!d3 && b3.done) begin d3 = 1'b1; cyc3 = c; end
            if (rst_v >= 0 && !d1 && b1.vec == 4'(rst_v)) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk({nm, " u1 reset mid-sweep"}, packed_out1(), 32'd0);
                chk({nm, " u3 reset mid-sweep"}, packed_out3(), 32'd0);
                return;
            end
            if (pulse_v >= 0 && !pulsed && b1.busy && b1.vec == 4'(pulse_v)) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
        end
        chk({nm, " finished in budget"}, 32'(d1 && d3), 32'd1);
        check_dut({nm, " u1"}, b1.busy, b1.done, b1.pass, b1.mismatch_cnt, b1.vec,
                  b1.first_fail_vec, b1.first_fail_valid, cyc1, 1);
        check_dut({nm, " u3"}, b3.busy, b3.done, b3.pass, b3.mismatch_cnt, b3.vec,
                  b3.first_fail_vec, b3.first_fail_valid, cyc3, 3);
    endtask

    task automatic clear_tab();
        for (int v = 0; v < 16; v++) err_tab[v] = '0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_tab();
        repeat (2) @(posedge clk);
        #1;
        chk("u1 reset state", packed_out1(), 32'd0);
        chk("u3 reset state", packed_out3(), 32'd0);
        rst = 1'b0;

        // All implementations agree.
        run("clean", -1, -1);

        // Single flipped output at vec 5.
        clear_tab();
        err_tab[5] = 4'b0100;
        run("single5", -1, -1);

        // Output 0 wrong on every odd vector.
        clear_tab();
        for (int v = 1; v < 16; v += 2) err_tab[v] = 4'b0001;
        run("odd", -1, -1);

        // Mid-sweep start ignored.
        clear_tab();
        run("pulse7", 7, -1);

        // Reset mid-sweep, then a clean sweep afterwards.
        run("rst9", -1, 9);
        run("after_rst", -1, -1);

        // Randomized error patterns; all-ones flips keep outputs in agreement.
        for (int t = 0; t < 6; t++) begin
            for (int v = 0; v < 16; v++) begin
                case ($urandom_range(0, 5))
                    0:       err_tab[v] = 4'($urandom);
                    1:       err_tab[v] = 4'hF;
                    default: err_tab[v] = 4'h0;
                endcase
            end
            run($sformatf("rand%0d", t), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/comb_sweep_checker.md
# comb_sweep_checker

Self-checking exhaustive sweep engine for small combinational functions implemented several ways, e.g. structural, dataflow, behavioural and primitive versions of the same function. It drives every N-bit input vector in ascending order and waits a programmable settle time per vector. It samples the M implementation outputs, counts vectors where they disagree, and records the first failing vector. It sits in simulation benches and in FPGA bring-up harnesses alongside the implementations under comparison.

## Interface
- N, 4, input vector width; sweep covers 2^N vectors (N = 1..16)
- M, 4, number of implementations compared (M >= 2)
- SETTLE, 1, cycles each vector is held before its outputs are sampled (>= 1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep
- vec  output  N  current input vector driven to all implementations
- y_in  input  M  outputs of the M implementations for `vec`
- busy  output  1  sweep in progress
- done  output  1  sweep finished; held until next accepted start
- pass  output  1  done and zero mismatches
- mismatch_cnt  output  N+1  number of vectors with disagreeing outputs
- first_fail_vec  output  N  first vector that mismatched
- first_fail_valid  output  1  first_fail_vec holds a real capture

## Operation
- States: IDLE, RUN, DONE (plus HALT under the configuration macro).
- Reset, applied at any clock edge including mid-sweep, drives these values at the next edge:
  - state = IDLE
  - vec, mismatch_cnt and first_fail_vec = 0
  - busy, done, pass and first_fail_valid = 0
- IDLE or DONE, start=1 -> RUN:
  - vec = 0, mismatch_cnt = 0, first_fail_valid = 0, settle counter = 0
  - busy = 1, done = 0, pass = 0
- RUN, start ignored:
  - Settle counter runs 0..SETTLE-1.
  - At the edge where the counter equals SETTLE-1, y_in is sampled.
  - Mismatch = NOT (all y_in bits 1 OR all y_in bits 0).
  - On mismatch: mismatch_cnt += 1. If first_fail_valid = 0, first_fail_vec = vec and first_fail_valid = 1.
  - Same edge, vec not all-ones: vec += 1 and the counter clears.
  - Same edge, vec all-ones: -> DONE, busy = 0, done = 1. pass = 1 iff the final mismatch_cnt (including this sample) is 0. vec holds all-ones and does not wrap.
- mismatch_cnt is N+1 bits wide, so it holds 2^N without saturating or wrapping.
- DONE: all results are held stable until rst or start.

## Timing
- Start accepted at edge t0 -> vec = 0 and busy = 1 visible after t0.
- Vector k is driven from edge t0 + k*SETTLE and sampled at edge t0 + (k+1)*SETTLE.
- done rises after edge t0 + 2^N*SETTLE; total sweep is 2^N*SETTLE cycles.
- y_in must be valid within SETTLE cycles of a vec change. Combinational implementations with SETTLE = 1 meet this.
- start and rst in the same cycle: rst wins.
- Result outputs are registered; there are no combinational paths from y_in to outputs.

## Configuration
- COMB_SWEEP_STOP_ON_FAIL_EN defined:
  - First mismatch moves RUN -> HALT at the sampling edge. mismatch_cnt = 1, first_fail_vec = failing vec.
  - vec stays frozen at the failing vector, busy = 0, done = 1, pass = 0.
  - HALT behaves like DONE for start and rst.
- Macro undefined: full sweep always runs; the HALT state does not exist.

## Test plan
- N=4, M=4, SETTLE=1, all y_in equal to one shared function -> done after 16 cycles, mismatch_cnt=0, pass=1, first_fail_valid=0, vec=4'hF.
- Invert y_in[2] only while vec=4'h5 -> mismatch_cnt=1, first_fail_vec=4'h5, first_fail_valid=1, pass=0.
- Invert y_in[0] whenever vec[0]=1 -> mismatch_cnt=8, first_fail_vec=4'h1. SETTLE=3 variant -> done exactly 48 cycles after start.
- Pulse start at vec=4'h7 mid-sweep -> ignored, sweep completes normally. Then assert rst at vec=4'h9 on a second sweep -> all outputs return to reset values next edge; a following start sweeps cleanly.
- Compile with COMB_SWEEP_STOP_ON_FAIL_EN and inject a mismatch at vec=4'h5 -> HALT with vec frozen at 4'h5, mismatch_cnt=1, done=1, busy=0, pass=0.
